// File: rtl/avr_seq.sv
// Instruction sequencer for a small AVR-style core: steers the fetch PC, gates
// datapath writes and stitches two-word instructions (JMP/LDS/STS) together.
module avr_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] instr,
    input  logic [7:0]  sreg,
    input  logic        hold,
    output logic [2:0]  pc_src,
    output logic [15:0] jmp,
    output logic        exec_en,
    output logic [15:0] exec_instr,
    output logic [15:0] d_addr,
    output logic        d_valid,
    output logic        busy,
    output logic [1:0]  dbg_state_o,
    output logic [15:0] dbg_op_latch_o
);

    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_WORD2 = 2'd2;

    localparam logic [2:0] PC_ZERO = 3'b000;
    localparam logic [2:0] PC_HOLD = 3'b001;
    localparam logic [2:0] PC_INC1 = 3'b010;
    localparam logic [2:0] PC_REL  = 3'b100;
    localparam logic [2:0] PC_ABS  = 3'b101;

    logic [1:0]  state_q, state_d;
    logic [15:0] op_latch_q, op_latch_d;
    logic [15:0] d_addr_q;

    logic        is_rjmp, is_brbs, is_brbc, br_taken;
    logic        is_jmp_w, is_lds_w, is_sts_w, is_two_word;
    logic        latch_is_jmp, latch_is_lds;
    logic [15:0] rjmp_off, br_off;

    assign is_rjmp     = (instr[15:12] == 4'b1100);
    assign is_brbs     = (instr[15:10] == 6'b111100);
    assign is_brbc     = (instr[15:10] == 6'b111101);
    assign br_taken    = is_brbs ? sreg[instr[2:0]] : ~sreg[instr[2:0]];
    assign is_jmp_w    = (instr[15:9] == 7'b1001010) && (instr[3:1] == 3'b110);
    assign is_lds_w    = (instr[15:9] == 7'b1001000) && (instr[3:0] == 4'b0000);
    assign is_sts_w    = (instr[15:9] == 7'b1001001) && (instr[3:0] == 4'b0000);
    assign is_two_word = is_jmp_w | is_lds_w | is_sts_w;

    // Only JMP/LDS/STS are ever latched, so a non-JMP latch with LDS bits is LDS.
    assign latch_is_jmp = (op_latch_q[15:9] == 7'b1001010) && (op_latch_q[3:1] == 3'b110);
    assign latch_is_lds = (op_latch_q[15:9] == 7'b1001000);

    // Offsets are relative to the branch word itself, hence the +1 (mod 2^16).
    assign rjmp_off = {{4{instr[11]}}, instr[11:0]} + 16'd1;
    assign br_off   = {{9{instr[9]}}, instr[9:3]} + 16'd1;

    always_comb begin
        pc_src     = PC_ZERO;
        jmp        = 16'h0000;
        exec_en    = 1'b0;
        exec_instr = 16'h0000;
        d_valid    = 1'b0;
        state_d    = state_q;
        op_latch_d = op_latch_q;
        if (RST) begin
            state_d    = ST_RST;
            op_latch_d = 16'h0000;
        end else begin
            case (state_q)
                ST_RUN: begin
                    exec_instr = instr;
                    if (hold) begin
                        pc_src = PC_HOLD;
                    end else if (is_rjmp) begin
                        pc_src = PC_REL;
                        jmp    = rjmp_off;
                    end else if (is_brbs || is_brbc) begin
                        pc_src = br_taken ? PC_REL : PC_INC1;
                        jmp    = br_taken ? br_off : 16'h0000;
                    end else if (is_two_word) begin
                        pc_src     = PC_INC1;
                        op_latch_d = instr;
                        state_d    = ST_WORD2;
                    end else begin
                        pc_src  = PC_INC1;
                        exec_en = 1'b1;
                    end
                end
                ST_WORD2: begin
                    exec_instr = op_latch_q;
                    if (hold) begin
                        pc_src = PC_HOLD;
                    end else begin
                        state_d = ST_RUN;
                        if (latch_is_jmp) begin
                            pc_src = PC_ABS;
                            jmp    = instr;
                        end else begin
                            pc_src  = PC_INC1;
                            d_valid = 1'b1;
                            exec_en = latch_is_lds;
                        end
                    end
                end
                ST_RST:  state_d = ST_RUN;
                default: state_d = ST_RST;
            endcase
        end
    end

    assign d_addr         = RST ? 16'h0000 : (d_valid ? instr : d_addr_q);
    assign busy           = RST || (state_q != ST_RUN);
    assign dbg_state_o    = state_q;
    assign dbg_op_latch_o = op_latch_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_RST;
            op_latch_q <= 16'h0000;
            d_addr_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            op_latch_q <= op_latch_d;
            d_addr_q   <= d_addr;
        end
    end

endmodule

// File: tb/tb_avr_seq.sv
// Bench for avr_seq: directed scenarios plus randomized instruction streams
// compared cycle by cycle against a pending-instruction reference model.
module tb_avr_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] instr;
    logic [7:0]  sreg;
    logic        hold;
    logic [2:0]  pc_src;
    logic [15:0] jmp;
    logic        exec_en;
    logic [15:0] exec_instr;
    logic [15:0] d_addr;
    logic        d_valid;
    logic        busy;
    logic [1:0]  dbg_state_o;
    logic [15:0] dbg_op_latch_o;

    int checks   = 0;
    int failures = 0;

    avr_seq dut (
        .CLK(CLK), .RST(RST), .instr(instr), .sreg(sreg), .hold(hold),
        .pc_src(pc_src), .jmp(jmp), .exec_en(exec_en), .exec_instr(exec_instr),
        .d_addr(d_addr), .d_valid(d_valid), .busy(busy),
        .dbg_state_o(dbg_state_o), .dbg_op_latch_o(dbg_op_latch_o)
    );

    always #5 CLK = ~CLK;

    localparam logic [15:0] RJMP_PAT = 16'b1100_????_????_????;
    localparam logic [15:0] BRBS_PAT = 16'b1111_00??_????_????;
    localparam logic [15:0] BRBC_PAT = 16'b1111_01??_????_????;
    localparam logic [15:0] JMP_PAT  = 16'b1001_010?_????_110?;
    localparam logic [15:0] LDS_PAT  = 16'b1001_000?_????_0000;
    localparam logic [15:0] STS_PAT  = 16'b1001_001?_????_0000;

    // Reference model: "just left reset", "a two-word op is waiting for its
    // operand word", and the last published data address.
    bit          m_after_rst = 1'b1;
    bit          m_pend      = 1'b0;
    logic [15:0] m_pend_word = 16'h0000;
    logic [15:0] m_daddr     = 16'h0000;

    logic        cur_r;
    logic [15:0] cur_i;
    logic [7:0]  cur_s;
    logic        cur_h;

    logic [53:0] exp_v;
    logic [53:0] obs_v;
    assign obs_v = {busy, pc_src, exec_en, d_valid, jmp, exec_instr, d_addr};

    function automatic logic [53:0] model_expect();
        logic        b = 1'b1;
        logic [2:0]  pc = 3'd0;
        logic        en = 1'b0;
        logic        dv = 1'b0;
        logic [15:0] j = 16'h0000;
        logic [15:0] ei = 16'h0000;
        logic [15:0] da = cur_r ? 16'h0000 : m_daddr;
        int          k;
        int          bitn;
        int          want;
        if (cur_r || m_after_rst) begin
            b = 1'b1;
        end else if (m_pend) begin
            ei = m_pend_word;
            if (cur_h) pc = 3'd1;
            else if (m_pend_word ==? JMP_PAT) begin
                pc = 3'd5;
                j  = cur_i;
            end else begin
                pc = 3'd2;
                dv = 1'b1;
                da = cur_i;
                en = (m_pend_word ==? LDS_PAT);
            end
        end else begin
            b  = 1'b0;
            ei = cur_i;
            if (cur_h) pc = 3'd1;
            else if (cur_i ==? RJMP_PAT) begin
                k = int'(cur_i) % 4096;
                if (k >= 2048) k = k - 4096;
                pc = 3'd4;
                j  = 16'((k + 1) & 16'hFFFF);
            end else if ((cur_i ==? BRBS_PAT) || (cur_i ==? BRBC_PAT)) begin
                bitn = int'(cur_i) % 8;
                k    = (int'(cur_i) / 8) % 128;
                if (k >= 64) k = k - 128;
                want = (cur_i ==? BRBS_PAT) ? 1 : 0;
                if (((int'(cur_s) >> bitn) % 2) == want) begin
                    pc = 3'd4;
                    j  = 16'((k + 1) & 16'hFFFF);
                end else pc = 3'd2;
            end else if ((cur_i ==? JMP_PAT) || (cur_i ==? LDS_PAT) || (cur_i ==? STS_PAT)) begin
                pc = 3'd2;
            end else begin
                pc = 3'd2;
                en = 1'b1;
            end
        end
        return {b, pc, en, dv, j, ei, da};
    endfunction

    task automatic model_update();
        if (cur_r) begin
            m_after_rst = 1'b1;
            m_pend      = 1'b0;
            m_pend_word = 16'h0000;
            m_daddr     = 16'h0000;
        end else if (m_after_rst) begin
            m_after_rst = 1'b0;
        end else if (!cur_h) begin
            if (m_pend) begin
                if (!(m_pend_word ==? JMP_PAT)) m_daddr = cur_i;
                m_pend = 1'b0;
            end else if ((cur_i ==? JMP_PAT) || (cur_i ==? LDS_PAT) || (cur_i ==? STS_PAT)) begin
                m_pend      = 1'b1;
                m_pend_word = cur_i;
            end
        end
    endtask

    task automatic apply(input logic r, input logic [15:0] i, input logic [7:0] s, input logic h);
        cur_r = r; cur_i = i; cur_s = s; cur_h = h;
        RST = r; instr = i; sreg = s; hold = h;
        exp_v = model_expect();
        @(negedge CLK);
    endtask

    task automatic advance();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w = 16'($urandom);
        case ($urandom_range(0, 7))
            0: w = {4'b1100, w[11:0]};
            1: w = {5'b11110, w[10:0]};
            2: w = {7'b1001010, w[8:4], 3'b110, w[0]};
            3: w = {7'b1001000, w[8:4], 4'b0000};
            4: w = {7'b1001001, w[8:4], 4'b0000};
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, 16'hC005, 8'hFF, 1'b1);
            checks++;
            if ({busy, pc_src, exec_en, d_valid, jmp, d_addr} !== {1'b1, 3'b000, 1'b0, 1'b0, 16'h0, 16'h0}) begin
                failures++;
                $display("FAIL reset_hold: got %h want %h", {busy, pc_src, exec_en, d_valid, jmp, d_addr},
                         {1'b1, 3'b000, 1'b0, 1'b0, 16'h0, 16'h0});
            end
            advance();
        end
        apply(1'b0, 16'h0000, 8'h00, 1'b1);
        checks++;
        if ({busy, pc_src, exec_en, exec_instr} !== {1'b1, 3'b000, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL reset_cycle0: got %h want %h", {busy, pc_src, exec_en, exec_instr}, {1'b1, 3'b000, 1'b0, 16'h0000});
        end
        advance();
        apply(1'b0, 16'h0000, 8'h00, 1'b0);
        checks++;
        if ({busy, pc_src, exec_en} !== {1'b0, 3'b010, 1'b1}) begin
            failures++;
            $display("FAIL reset_cycle1: got %h want %h", {busy, pc_src, exec_en}, {1'b0, 3'b010, 1'b1});
        end
        advance();
    endtask

    task automatic test_rjmp();
        apply(1'b0, 16'hCFFF, 8'h00, 1'b0);
        checks++;
        if ({pc_src, jmp, exec_en} !== {3'b100, 16'h0000, 1'b0}) begin
            failures++;
            $display("FAIL rjmp_minus1: got %h want %h", {pc_src, jmp, exec_en}, {3'b100, 16'h0000, 1'b0});
        end
        advance();
        apply(1'b0, 16'hC005, 8'h00, 1'b0);
        checks++;
        if ({pc_src, jmp, exec_en} !== {3'b100, 16'h0006, 1'b0}) begin
            failures++;
            $display("FAIL rjmp_plus5: got %h want %h", {pc_src, jmp, exec_en}, {3'b100, 16'h0006, 1'b0});
        end
        advance();
        for (int n = 0; n < 20; n++) begin
            apply(1'b0, {4'b1100, 12'($urandom)}, 8'($urandom), 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL rjmp_rand instr=%h: got %h want %h", cur_i, obs_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_branch();
        apply(1'b0, 16'hF3F9, 8'h02, 1'b0);
        checks++;
        if ({pc_src, jmp, exec_en} !== {3'b100, 16'h0000, 1'b0}) begin
            failures++;
            $display("FAIL brbs_taken: got %h want %h", {pc_src, jmp, exec_en}, {3'b100, 16'h0000, 1'b0});
        end
        advance();
        apply(1'b0, 16'hF3F9, 8'h00, 1'b0);
        checks++;
        if ({pc_src, exec_en} !== {3'b010, 1'b0}) begin
            failures++;
            $display("FAIL brbs_not_taken: got %h want %h", {pc_src, exec_en}, {3'b010, 1'b0});
        end
        advance();
        for (int n = 0; n < 40; n++) begin
            apply(1'b0, {5'b11110, 11'($urandom)}, 8'($urandom), 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL branch_rand instr=%h sreg=%h: got %h want %h", cur_i, cur_s, obs_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_jmp();
        apply(1'b0, 16'h940C, 8'h00, 1'b0);
        checks++;
        if ({pc_src, busy, exec_en} !== {3'b010, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL jmp_word1: got %h want %h", {pc_src, busy, exec_en}, {3'b010, 1'b0, 1'b0});
        end
        advance();
        apply(1'b0, 16'h1234, 8'h00, 1'b0);
        checks++;
        if ({pc_src, jmp, exec_instr, busy, exec_en} !== {3'b101, 16'h1234, 16'h940C, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL jmp_word2: got %h want %h", {pc_src, jmp, exec_instr, busy, exec_en},
                     {3'b101, 16'h1234, 16'h940C, 1'b1, 1'b0});
        end
        advance();
        apply(1'b0, 16'h95FD, 8'h00, 1'b0);
        advance();
        apply(1'b0, 16'hABCD, 8'h00, 1'b0);
        checks++;
        if ({pc_src, jmp} !== {3'b101, 16'hABCD}) begin
            failures++;
            $display("FAIL jmp_high_k_ignored: got %h want %h", {pc_src, jmp}, {3'b101, 16'hABCD});
        end
        advance();
    endtask

    task automatic test_lds_sts_hold();
        apply(1'b0, 16'h9100, 8'h00, 1'b0);
        advance();
        for (int c = 0; c < 2; c++) begin
            apply(1'b0, 16'h0060, 8'h00, 1'b1);
            checks++;
            if ({pc_src, exec_en, d_valid, busy} !== {3'b001, 1'b0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL lds_hold%0d: got %h want %h", c, {pc_src, exec_en, d_valid, busy}, {3'b001, 1'b0, 1'b0, 1'b1});
            end
            advance();
        end
        apply(1'b0, 16'h0060, 8'h00, 1'b0);
        checks++;
        if ({pc_src, d_addr, d_valid, exec_en, exec_instr} !== {3'b010, 16'h0060, 1'b1, 1'b1, 16'h9100}) begin
            failures++;
            $display("FAIL lds_word2: got %h want %h", {pc_src, d_addr, d_valid, exec_en, exec_instr},
                     {3'b010, 16'h0060, 1'b1, 1'b1, 16'h9100});
        end
        advance();
        apply(1'b0, 16'h0000, 8'h00, 1'b0);
        checks++;
        if ({d_valid, d_addr} !== {1'b0, 16'h0060}) begin
            failures++;
            $display("FAIL d_addr_hold: got %h want %h", {d_valid, d_addr}, {1'b0, 16'h0060});
        end
        advance();
        apply(1'b0, 16'h9300, 8'h00, 1'b0);
        advance();
        apply(1'b0, 16'h0200, 8'h00, 1'b0);
        checks++;
        if ({pc_src, d_addr, d_valid, exec_en, exec_instr} !== {3'b010, 16'h0200, 1'b1, 1'b0, 16'h9300}) begin
            failures++;
            $display("FAIL sts_word2: got %h want %h", {pc_src, d_addr, d_valid, exec_en, exec_instr},
                     {3'b010, 16'h0200, 1'b1, 1'b0, 16'h9300});
        end
        advance();
    endtask

    task automatic test_reset_mid();
        apply(1'b0, 16'h940C, 8'h00, 1'b0);
        advance();
        apply(1'b1, 16'h1234, 8'h00, 1'b0);
        checks++;
        if ({pc_src, jmp, busy} !== {3'b000, 16'h0000, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_nojump: got %h want %h", {pc_src, jmp, busy}, {3'b000, 16'h0000, 1'b1});
        end
        advance();
        apply(1'b0, 16'h1234, 8'h00, 1'b0);
        checks++;
        if ({pc_src, exec_en, busy, dbg_op_latch_o} !== {3'b000, 1'b0, 1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL reset_mid_latch: got %h want %h", {pc_src, exec_en, busy, dbg_op_latch_o},
                     {3'b000, 1'b0, 1'b1, 16'h0000});
        end
        advance();
        apply(1'b0, 16'h0000, 8'h00, 1'b0);
        checks++;
        if ({pc_src, exec_en, busy} !== {3'b010, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_resume: got %h want %h", {pc_src, exec_en, busy}, {3'b010, 1'b1, 1'b0});
        end
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            apply(($urandom_range(0, 49) == 0), rand_word(), 8'($urandom), ($urandom_range(0, 3) == 0));
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL random[%0d] rst=%b hold=%b instr=%h sreg=%h: got %h want %h",
                         n, cur_r, cur_h, cur_i, cur_s, obs_v, exp_v);
            end
            advance();
        end
    endtask

    initial begin
        RST = 1'b1; instr = 16'h0000; sreg = 8'h00; hold = 1'b0;
        cur_r = 1'b1; cur_i = 16'h0000; cur_s = 8'h00; cur_h = 1'b0;
        @(posedge CLK);
        #1;
        test_reset();
        test_rjmp();
        test_branch();
        test_jmp();
        test_lds_sts_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
